// File: rtl/unified_mem_arbiter_if.sv
// Purpose : bundles the fetch, data and memory-side signals of the unified memory arbiter.
// Ports   : fetch (if_*), data (dm_*), backing memory (mem_*), and the stall_if/stall_mem hazard outputs.
// Modports: slave = arbiter side, master = pipeline/memory side driving the arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Purpose     : shares one single-port memory between fetch (IF) and data (MEM) stages, one grant at a time.
// Latency     : request seen idle in cycle 0 -> mem_en cycles 1..MEM_LAT -> ready pulse in cycle MEM_LAT+1.
// Backpressure: requesters hold req until their ready pulse; stall_if/stall_mem tell the hazard unit to freeze.
// Ports: clk, rst_n (synchronous, active-low) and `bus` (unified_mem_arbiter_if.slave) carrying if_*, dm_*, mem_*, stall_*.
// Build option: define MEM_ARB_RR_EN for round-robin tie-break; otherwise the data side always wins ties.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2      // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    unified_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arbState_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    arbState_t         stateQ, stateD;
    logic [3:0]        cntQ, cntD;

    logic              memEnQ, memEnD;
    logic              memWeQ, memWeD;
    logic [ADDR_W-1:0] memAddrQ, memAddrD;
    logic [DATA_W-1:0] memWdataQ, memWdataD;
    logic [DATA_W-1:0] ifRdataQ, ifRdataD;
    logic [DATA_W-1:0] dmRdataQ, dmRdataD;
    logic              ifReadyQ, ifReadyD;
    logic              dmReadyQ, dmReadyD;

    logic              ifElig, dmElig;
    logic              grantDm, grantIf;
    logic              lastCycle;

    // A requester is ignored in its own ready cycle: its req is still the
    // stale one from the access that just finished.
    assign ifElig    = bus.if_req & ~ifReadyQ;
    assign dmElig    = bus.dm_req & ~dmReadyQ;
    assign lastCycle = (cntQ == 4'd0);

`ifdef MEM_ARB_RR_EN
    logic prioDmQ, prioDmD;    // 1: data side wins the next tie
    assign grantDm = (stateQ == IDLE) & dmElig & (~ifElig | prioDmQ);
`else
    // Data side always wins ties so the older instruction drains first.
    assign grantDm = (stateQ == IDLE) & dmElig;
`endif
    assign grantIf = (stateQ == IDLE) & ifElig & ~grantDm;

    // State register plus the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            cntQ      <= 4'd0;
            memEnQ    <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            ifRdataQ  <= '0;
            dmRdataQ  <= '0;
            ifReadyQ  <= 1'b0;
            dmReadyQ  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prioDmQ   <= 1'b1;
`endif
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            memEnQ    <= memEnD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            ifRdataQ  <= ifRdataD;
            dmRdataQ  <= dmRdataD;
            ifReadyQ  <= ifReadyD;
            dmReadyQ  <= dmReadyD;
`ifdef MEM_ARB_RR_EN
            prioDmQ   <= prioDmD;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
`ifdef MEM_ARB_RR_EN
        prioDmD = prioDmQ;
`endif
        unique case (stateQ)
            IDLE: begin
                if (grantDm) begin
                    stateD = BUSY_DM;
                    cntD   = CNT_LOAD;
`ifdef MEM_ARB_RR_EN
                    prioDmD = 1'b0;
`endif
                end else if (grantIf) begin
                    stateD = BUSY_IF;
                    cntD   = CNT_LOAD;
`ifdef MEM_ARB_RR_EN
                    prioDmD = 1'b1;
`endif
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (lastCycle) begin
                    stateD = IDLE;
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        memEnD    = memEnQ;
        memWeD    = memWeQ;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        ifRdataD  = ifRdataQ;
        dmRdataD  = dmRdataQ;
        ifReadyD  = 1'b0;
        dmReadyD  = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (grantDm) begin
                    memEnD    = 1'b1;
                    memWeD    = bus.dm_we;
                    memAddrD  = bus.dm_addr;
                    memWdataD = bus.dm_wdata;
                end else if (grantIf) begin
                    // Fetches are reads; mem_wdata keeps its last value.
                    memEnD   = 1'b1;
                    memWeD   = 1'b0;
                    memAddrD = bus.if_addr;
                end
            end
            BUSY_IF: begin
                if (lastCycle) begin
                    ifRdataD = bus.mem_rdata;
                    ifReadyD = 1'b1;
                    memEnD   = 1'b0;
                    memWeD   = 1'b0;
                end
            end
            BUSY_DM: begin
                if (lastCycle) begin
                    // Stores leave dm_rdata untouched.
                    if (!memWeQ) begin
                        dmRdataD = bus.mem_rdata;
                    end
                    dmReadyD = 1'b1;
                    memEnD   = 1'b0;
                    memWeD   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_en    = memEnQ;
    assign bus.mem_we    = memWeQ;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;
    assign bus.if_rdata  = ifRdataQ;
    assign bus.if_ready  = ifReadyQ;
    assign bus.dm_rdata  = dmRdataQ;
    assign bus.dm_ready  = dmReadyQ;
    assign bus.stall_if  = bus.if_req & ~ifReadyQ;
    assign bus.stall_mem = bus.dm_req & ~dmReadyQ;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose: drives two arbiters (MEM_LAT=2 and MEM_LAT=1) with random fetch/load/store traffic and resets.
// Checks : every cycle against a transaction-schedule model (grant cycle, busy window, ready cycle).
// Summary: one line with total and failed comparison counts.
module tb_unified_mem_arbiter;
    localparam int NI = 2;
    localparam int LAT [NI] = '{2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // Stimulus
    logic        rstN    [NI];
    logic        ifReq   [NI];
    logic        dmReq   [NI];
    logic        dmWe    [NI];
    logic [31:0] ifAddr  [NI];
    logic [31:0] dmAddr  [NI];
    logic [31:0] dmWdata [NI];

    // Observed
    logic        memEn    [NI];
    logic        memWe    [NI];
    logic        ifReady  [NI];
    logic        dmReady  [NI];
    logic        stallIf  [NI];
    logic        stallMem [NI];
    logic [31:0] memAddr  [NI];
    logic [31:0] memWdata [NI];
    logic [31:0] ifRdata  [NI];
    logic [31:0] dmRdata  [NI];

    // Backing memory content as a pure function of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rndAddr();
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gInst
        unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT[g])) dut (
            .clk   (clk),
            .rst_n (rstN[g]),
            .bus   (bus)
        );
        assign bus.if_req    = ifReq[g];
        assign bus.if_addr   = ifAddr[g];
        assign bus.dm_req    = dmReq[g];
        assign bus.dm_we     = dmWe[g];
        assign bus.dm_addr   = dmAddr[g];
        assign bus.dm_wdata  = dmWdata[g];
        assign bus.mem_rdata = bus.mem_en ? memWord(bus.mem_addr) : (32'hA5A5_A5A5 ^ 32'(cyc));
        assign memEn[g]    = bus.mem_en;
        assign memWe[g]    = bus.mem_we;
        assign memAddr[g]  = bus.mem_addr;
        assign memWdata[g] = bus.mem_wdata;
        assign ifRdata[g]  = bus.if_rdata;
        assign ifReady[g]  = bus.if_ready;
        assign dmRdata[g]  = bus.dm_rdata;
        assign dmReady[g]  = bus.dm_ready;
        assign stallIf[g]  = bus.stall_if;
        assign stallMem[g] = bus.stall_mem;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one outstanding job per arbiter, described by who owns
    // the memory, when it was granted and what it latched.
    bit          mValid   [NI];
    bit          jAct     [NI];
    bit          jDm      [NI];
    bit          jWe      [NI];
    int          jGrant   [NI];
    logic [31:0] jAddr    [NI];
    logic [31:0] eMemAddr [NI];
    logic [31:0] eMemWd   [NI];
    logic [31:0] eIfRd    [NI];
    logic [31:0] eDmRd    [NI];
    bit          favorDm  [NI];
    bit          justRst  [NI];
    bit          sawIf    [NI];
    bit          sawDm    [NI];
    int          rdyCnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit done, eEn, eWe, eIfRdy, eDmRdy, eligIf, eligDm, pickDm;
            int L;
            L = LAT[i];
            sawIf[i] = ifReady[i];
            sawDm[i] = dmReady[i];
            if (ifReady[i] || dmReady[i]) rdyCnt++;
            if (mValid[i]) begin
                done   = jAct[i] && (cyc == jGrant[i] + L + 1);
                eEn    = jAct[i] && (cyc >= jGrant[i] + 1) && (cyc <= jGrant[i] + L);
                eWe    = eEn && jDm[i] && jWe[i];
                eIfRdy = done && !jDm[i];
                eDmRdy = done && jDm[i];
                if (eIfRdy) eIfRd[i] = memWord(jAddr[i]);
                if (eDmRdy && !jWe[i]) eDmRd[i] = memWord(jAddr[i]);
                if (done) jAct[i] = 1'b0;

                checkVal($sformatf("u%0d.mem_en", i),    32'(memEn[i]),    32'(eEn));
                checkVal($sformatf("u%0d.mem_we", i),    32'(memWe[i]),    32'(eWe));
                checkVal($sformatf("u%0d.mem_addr", i),  memAddr[i],       eMemAddr[i]);
                checkVal($sformatf("u%0d.if_ready", i),  32'(ifReady[i]),  32'(eIfRdy));
                checkVal($sformatf("u%0d.dm_ready", i),  32'(dmReady[i]),  32'(eDmRdy));
                checkVal($sformatf("u%0d.if_rdata", i),  ifRdata[i],       eIfRd[i]);
                checkVal($sformatf("u%0d.dm_rdata", i),  dmRdata[i],       eDmRd[i]);
                checkVal($sformatf("u%0d.stall_if", i),  32'(stallIf[i]),  32'(ifReq[i] && !eIfRdy));
                checkVal($sformatf("u%0d.stall_mem", i), 32'(stallMem[i]), 32'(dmReq[i] && !eDmRdy));
                if (eWe || justRst[i])
                    checkVal($sformatf("u%0d.mem_wdata", i), memWdata[i], eMemWd[i]);
                justRst[i] = 1'b0;

                // Arbitration decision taken at the edge closing this cycle.
                if (rstN[i] && !jAct[i]) begin
                    eligIf = ifReq[i] && !eIfRdy;
                    eligDm = dmReq[i] && !eDmRdy;
`ifdef MEM_ARB_RR_EN
                    pickDm = eligDm && (!eligIf || favorDm[i]);
`else
                    pickDm = eligDm;
`endif
                    if (pickDm || eligIf) begin
                        jAct[i]     = 1'b1;
                        jDm[i]      = pickDm;
                        jWe[i]      = pickDm && dmWe[i];
                        jGrant[i]   = cyc;
                        jAddr[i]    = pickDm ? dmAddr[i] : ifAddr[i];
                        eMemAddr[i] = jAddr[i];
                        if (pickDm) eMemWd[i] = dmWdata[i];
                        favorDm[i]  = !pickDm;
                    end
                end
            end
            if (!rstN[i]) begin
                mValid[i]   = 1'b1;
                jAct[i]     = 1'b0;
                eMemAddr[i] = '0;
                eMemWd[i]   = '0;
                eIfRd[i]    = '0;
                eDmRd[i]    = '0;
                favorDm[i]  = 1'b1;
                justRst[i]  = 1'b1;
            end
        end
    end

    // Legal requesters: hold req until ready, then drop or present a new access.
    task automatic runPhase(input int n, input int pIf, input int pDm, input int pSt,
                            input int pKeep, input int pRst);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                rstN[i] = ($urandom_range(0, 99) >= pRst);
                if (ifReq[i] && sawIf[i]) begin
                    if ($urandom_range(0, 99) < pKeep) ifAddr[i] = rndAddr();
                    else                               ifReq[i]  = 1'b0;
                end else if (!ifReq[i] && $urandom_range(0, 99) < pIf) begin
                    ifReq[i]  = 1'b1;
                    ifAddr[i] = rndAddr();
                end
                if (dmReq[i] && sawDm[i]) begin
                    if ($urandom_range(0, 99) < pKeep) begin
                        dmAddr[i]  = rndAddr();
                        dmWe[i]    = ($urandom_range(0, 99) < pSt);
                        dmWdata[i] = $urandom;
                    end else begin
                        dmReq[i] = 1'b0;
                    end
                end else if (!dmReq[i] && $urandom_range(0, 99) < pDm) begin
                    dmReq[i]   = 1'b1;
                    dmAddr[i]  = rndAddr();
                    dmWe[i]    = ($urandom_range(0, 99) < pSt);
                    dmWdata[i] = $urandom;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rstN[i] = 1'b0; ifReq[i] = 1'b0; dmReq[i] = 1'b0; dmWe[i] = 1'b0;
            ifAddr[i] = '0; dmAddr[i] = '0; dmWdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        // Plain fetch of the instruction at 0x10.
        for (int i = 0; i < NI; i++) begin
            rstN[i] = 1'b1; ifReq[i] = 1'b1; ifAddr[i] = 32'h0000_0010;
        end
        runPhase(40, 100, 0, 0, 50, 0);
        // Store 0xDEADBEEF to 0x104 while fetches keep flowing.
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (!dmReq[i]) begin
                dmReq[i] = 1'b1; dmWe[i] = 1'b1; dmAddr[i] = 32'h104; dmWdata[i] = 32'hDEAD_BEEF;
            end
        end
        runPhase(40, 30, 0, 100, 60, 0);
        // Both sides held continuously: tie-break behaviour and IF stalling.
        runPhase(60, 100, 100, 0, 100, 0);
        // Mixed loads/stores with random one-cycle resets.
        runPhase(1500, 40, 40, 40, 50, 3);
        @(negedge clk);
        checkVal("progress", 32'(rdyCnt > 100), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
